// File: rtl/etx_arbiter_nch_pkg.sv
// -----------------------------------------------------------------------------
// etx_arbiter_nch_pkg
// Shared emesh packet layout for the elink TX arbiter: field offsets, datamode
// encodings and a small header decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package etx_arbiter_nch_pkg;

    localparam int PKT_WRITE_BIT    = 0;
    localparam int PKT_DATAMODE_LSB = 1;
    localparam int PKT_CTRLMODE_LSB = 3;
    localparam int PKT_DSTADDR_LSB  = 8;
    localparam int PKT_DATA_LSB     = 40;
    localparam int PKT_SRCADDR_LSB  = 72;

    typedef enum logic [1:0] {
        DM_BYTE   = 2'b00,
        DM_HALF   = 2'b01,
        DM_WORD   = 2'b10,
        DM_DOUBLE = 2'b11
    } datamode_e;

    // True for a write-double header: the only packet type that can open or
    // extend a burst.
    function automatic logic is_write_double(input logic [7:0] hdr);
        return hdr[PKT_WRITE_BIT] && (hdr[PKT_DATAMODE_LSB +: 2] == DM_DOUBLE);
    endfunction

endpackage

// File: rtl/etx_arbiter_nch_rr_arbiter.sv
// -----------------------------------------------------------------------------
// etx_rr_arbiter
// Combinational one-hot arbiter. RR=1: round-robin, search starts at ptr+1
// modulo NCH. RR=0: fixed priority, lowest index wins.
// Ports:
//   req   in   NCH          eligible requests
//   ptr   in   clog2(NCH)   index of the last granted channel (RR only)
//   grant out  NCH          one-hot grant, zero when no request
// -----------------------------------------------------------------------------
module etx_rr_arbiter #(
    parameter int NCH = 3,
    parameter int RR  = 1
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         grant
);

    // Scan from lowest to highest priority so the last hit (highest priority)
    // is the one left standing in grant.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        if (RR != 0) begin
            for (int k = NCH; k >= 1; k--) begin
                idx = (int'(ptr) + k) % NCH;
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/etx_arbiter_nch.sv
// -----------------------------------------------------------------------------
// etx_arbiter_nch
// N-channel elink TX arbiter. Merges NCH emesh packet streams into one
// registered output stream with round-robin or fixed priority, per-channel
// blocking and write-double burst lock.
// Ports:
//   clk         in   1        clock
//   reset       in   1        synchronous active-high reset
//   in_access   in   NCH      per-channel packet valid
//   in_packet   in   NCH*PW   channel i packet at [i*PW +: PW]
//   in_block    in   NCH      channel i ineligible this cycle
//   in_wait     out  NCH      per-channel pushback, hold packet while high
//   out_access  out  1        registered output valid
//   out_packet  out  PW       registered output packet
//   out_burst   out  1        high on beats 2..n of a locked burst
//   out_chan    out  NCH      one-hot source channel of out_packet
//   out_wait    in   1        downstream pushback, output holds while high
// -----------------------------------------------------------------------------
module etx_arbiter_nch
    import etx_arbiter_nch_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int PW       = 104,
    parameter int AW       = 32,
    parameter int RR       = 1,
    parameter int BURST_EN = 1,
    parameter int MAXBURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    in_access,
    input  logic [NCH*PW-1:0] in_packet,
    input  logic [NCH-1:0]    in_block,
    output logic [NCH-1:0]    in_wait,
    output logic              out_access,
    output logic [PW-1:0]     out_packet,
    output logic              out_burst,
    output logic [NCH-1:0]    out_chan,
    input  logic              out_wait
);

    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXBURST);

    logic [NCH-1:0] req;
    logic [NCH-1:0] arb_grant;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] lock_onehot;
    logic           load;
    logic           any_req;
    logic           hold_lock;

    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  lock_chan;
    logic [IW-1:0]  grant_idx;
    logic           lock;
    logic [CW-1:0]  burst_cnt;
    logic [AW-1:0]  prev_dstaddr;

    logic [PW-1:0]  lock_pkt;
    logic [PW-1:0]  grant_pkt;
    logic [AW-1:0]  lock_dst;

    assign req     = in_access & ~in_block;
    assign load    = ~out_access | ~out_wait;
    assign any_req = |req;

    always_comb begin
        lock_pkt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (lock_chan == IW'(i)) begin
                lock_pkt = in_packet[i*PW +: PW];
            end
        end
    end

    assign lock_dst = lock_pkt[PKT_DSTADDR_LSB +: AW];

    // The locked channel keeps the output only while it presents the next
    // sequential write-double and the burst has room left; otherwise this same
    // cycle falls back to normal arbitration.
    assign hold_lock = (BURST_EN != 0) && lock && req[lock_chan]
                       && is_write_double(lock_pkt[7:0])
                       && (lock_dst == prev_dstaddr + AW'(8))
                       && (burst_cnt < MAX_CNT);

    etx_rr_arbiter #(
        .NCH (NCH),
        .RR  (RR)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    assign lock_onehot = {{(NCH-1){1'b0}}, 1'b1} << lock_chan;
    assign grant       = hold_lock ? lock_onehot : arb_grant;

    always_comb begin
        grant_pkt = '0;
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                grant_pkt = in_packet[i*PW +: PW];
                grant_idx = IW'(i);
            end
        end
    end

    assign in_wait = in_access & ~(grant & {NCH{load}});

    always_ff @(posedge clk) begin
        if (reset) begin
            out_access   <= 1'b0;
            out_packet   <= '0;
            out_burst    <= 1'b0;
            out_chan     <= '0;
            rr_ptr       <= IW'(NCH - 1);
            lock         <= 1'b0;
            lock_chan    <= '0;
            burst_cnt    <= '0;
            prev_dstaddr <= '0;
        end else if (load) begin
            if (any_req) begin
                out_access   <= 1'b1;
                out_packet   <= grant_pkt;
                out_chan     <= grant;
                out_burst    <= hold_lock;
                rr_ptr       <= grant_idx;
                prev_dstaddr <= grant_pkt[PKT_DSTADDR_LSB +: AW];
                if (hold_lock) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end else if ((BURST_EN != 0) && is_write_double(grant_pkt[7:0])) begin
                    // Any write-double loaded outside a held burst opens a new
                    // lock as beat 1.
                    lock      <= 1'b1;
                    lock_chan <= grant_idx;
                    burst_cnt <= CW'(1);
                end else begin
                    lock      <= 1'b0;
                    burst_cnt <= '0;
                end
            end else begin
                out_access <= 1'b0;
                out_burst  <= 1'b0;
                out_chan   <= '0;
                lock       <= 1'b0;
                burst_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_etx_arbiter_nch.sv
module tb_etx_arbiter_nch;

    localparam int NCH = 3;
    localparam int PW  = 104;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    in_access;
    logic [NCH*PW-1:0] in_packet;
    logic [NCH-1:0]    in_block;
    logic              out_wait;

    logic [NCH-1:0]    rr_wait,   fp_wait;
    logic              rr_access, fp_access;
    logic [PW-1:0]     rr_packet, fp_packet;
    logic              rr_burst,  fp_burst;
    logic [NCH-1:0]    rr_chan,   fp_chan;

    etx_arbiter_nch #(
        .NCH(NCH), .PW(PW), .AW(32), .RR(1), .BURST_EN(1), .MAXBURST(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_access(in_access), .in_packet(in_packet), .in_block(in_block),
        .in_wait(rr_wait),
        .out_access(rr_access), .out_packet(rr_packet), .out_burst(rr_burst),
        .out_chan(rr_chan), .out_wait(out_wait)
    );

    etx_arbiter_nch #(
        .NCH(NCH), .PW(PW), .AW(32), .RR(0), .BURST_EN(1), .MAXBURST(16)
    ) dut_fp (
        .clk(clk), .reset(reset),
        .in_access(in_access), .in_packet(in_packet), .in_block(in_block),
        .in_wait(fp_wait),
        .out_access(fp_access), .out_packet(fp_packet), .out_burst(fp_burst),
        .out_chan(fp_chan), .out_wait(out_wait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [31:0] addr, input logic wr,
                                         input logic [1:0] dm, input logic [31:0] data);
        return {32'hA5A5_0000, data, addr, 5'd0, dm, wr};
    endfunction

    function automatic logic [31:0] dst_of(input logic [PW-1:0] p);
        return p[39:8];
    endfunction

    typedef struct {
        logic [2:0] acc;
        logic [2:0] blk;
        logic       ow;
        logic [2:0] wait_e;
        logic       acc_e;
        logic [2:0] chan_e;
        logic       burst_e;
    } vec_t;

    function automatic vec_t v(input logic [2:0] acc, input logic [2:0] blk, input logic ow,
                               input logic [2:0] wait_e, input logic acc_e,
                               input logic [2:0] chan_e, input logic burst_e);
        vec_t r;
        r.acc = acc; r.blk = blk; r.ow = ow; r.wait_e = wait_e;
        r.acc_e = acc_e; r.chan_e = chan_e; r.burst_e = burst_e;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_access = '0;
        in_block  = '0;
        out_wait  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t            tbl[16];
    logic [PW-1:0]   pk[3];
    logic [PW-1:0]   exp_pkt;
    int              sched[$];
    int              k1;
    int              g;
    logic [31:0]     addr;
    logic            acc1;
    logic            exp_b;
    logic [31:0]     wrap_addr[5];
    logic [2:0]      wrap_blk[5];
    logic            wrap_acc[5];
    logic            wrap_bst[5];

    initial begin
        reset     = 1'b1;
        in_access = '0;
        in_block  = '0;
        in_packet = '0;
        out_wait  = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset out_access", rr_access, 1'b0);
        check("reset out_packet", rr_packet, '0);
        check("reset out_burst",  rr_burst,  1'b0);
        check("reset out_chan",   rr_chan,   3'b000);
        check("reset fp out_access", fp_access, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table: RR rotation, stall, block, idle ----------------
        for (int i = 0; i < NCH; i++) begin
            pk[i] = mk(32'h100 * (i + 1), 1'b1, 2'b10, 32'hD0 + i);
            in_packet[i*PW +: PW] = pk[i];
        end

        tbl[0]  = v(3'b111, 3'b000, 1'b0, 3'b110, 1'b1, 3'b001, 1'b0);
        tbl[1]  = v(3'b111, 3'b000, 1'b0, 3'b101, 1'b1, 3'b010, 1'b0);
        tbl[2]  = v(3'b111, 3'b000, 1'b0, 3'b011, 1'b1, 3'b100, 1'b0);
        tbl[3]  = v(3'b111, 3'b000, 1'b0, 3'b110, 1'b1, 3'b001, 1'b0);
        tbl[4]  = v(3'b111, 3'b000, 1'b0, 3'b101, 1'b1, 3'b010, 1'b0);
        tbl[5]  = v(3'b111, 3'b000, 1'b0, 3'b011, 1'b1, 3'b100, 1'b0);
        tbl[6]  = v(3'b111, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100, 1'b0);
        tbl[7]  = v(3'b111, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100, 1'b0);
        tbl[8]  = v(3'b111, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100, 1'b0);
        tbl[9]  = v(3'b111, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100, 1'b0);
        tbl[10] = v(3'b111, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100, 1'b0);
        tbl[11] = v(3'b111, 3'b000, 1'b0, 3'b110, 1'b1, 3'b001, 1'b0);
        tbl[12] = v(3'b111, 3'b000, 1'b0, 3'b101, 1'b1, 3'b010, 1'b0);
        tbl[13] = v(3'b111, 3'b010, 1'b0, 3'b011, 1'b1, 3'b100, 1'b0);
        tbl[14] = v(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        tbl[15] = v(3'b001, 3'b001, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0);

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            in_access = tbl[r].acc;
            in_block  = tbl[r].blk;
            out_wait  = tbl[r].ow;
            #2;
            check($sformatf("tbl%0d in_wait", r), rr_wait, tbl[r].wait_e);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d out_access", r), rr_access, tbl[r].acc_e);
            check($sformatf("tbl%0d out_chan", r),   rr_chan,   tbl[r].chan_e);
            check($sformatf("tbl%0d out_burst", r),  rr_burst,  tbl[r].burst_e);
            if (tbl[r].acc_e) begin
                exp_pkt = tbl[r].chan_e[0] ? pk[0] : (tbl[r].chan_e[1] ? pk[1] : pk[2]);
                check($sformatf("tbl%0d out_packet", r), rr_packet, exp_pkt);
            end
        end

        // ---------------- fixed priority ----------------
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_block  = '0;
            out_wait  = 1'b0;
            in_access = (c < 4) ? 3'b101 : 3'b100;
            #2;
            check($sformatf("fp%0d in_wait", c), fp_wait, (c < 4) ? 3'b100 : 3'b000);
            @(posedge clk);
            #1;
            check($sformatf("fp%0d out_chan", c),   fp_chan,   (c < 4) ? 3'b001 : 3'b100);
            check($sformatf("fp%0d out_packet", c), fp_packet, (c < 4) ? pk[0] : pk[2]);
        end

        // ---------------- burst lock with MAXBURST ----------------
        do_reset();
        sched.push_back(0);
        repeat (16) sched.push_back(1);
        sched.push_back(0);
        repeat (4) sched.push_back(1);
        sched.push_back(0);
        sched.push_back(0);
        k1 = 0;
        in_packet[2*PW +: PW] = mk(32'h900, 1'b1, 2'b10, 32'h2);
        for (int c = 0; c < sched.size(); c++) begin
            @(negedge clk);
            acc1      = (k1 < 20);
            addr      = 32'h1000 + 32'(8 * k1);
            in_access = {1'b0, acc1, 1'b1};
            in_block  = '0;
            out_wait  = 1'b0;
            in_packet[0*PW +: PW] = mk(32'h500, 1'b0, 2'b10, 32'h0);
            in_packet[1*PW +: PW] = mk(addr, 1'b1, 2'b11, 32'(k1));
            g = sched[c];
            #2;
            check($sformatf("burst%0d in_wait", c), rr_wait,
                  (g == 0) ? {1'b0, acc1, 1'b0} : 3'b001);
            @(posedge clk);
            #1;
            // beats 1 and 17 of channel 1 open a lock; every other ch1 beat continues one
            exp_b = (g == 1) && (k1 != 0) && (k1 != 16);
            check($sformatf("burst%0d out_chan", c), rr_chan, (g == 0) ? 3'b001 : 3'b010);
            check($sformatf("burst%0d out_burst", c), rr_burst, exp_b);
            check($sformatf("burst%0d out_dst", c), dst_of(rr_packet),
                  (g == 1) ? addr : 32'h500);
            if (g == 1) k1++;
        end

        // ---------------- address wrap and block mid-burst ----------------
        do_reset();
        wrap_addr[0] = 32'hFFFF_FFF0; wrap_blk[0] = 3'b000; wrap_acc[0] = 1'b1; wrap_bst[0] = 1'b0;
        wrap_addr[1] = 32'hFFFF_FFF8; wrap_blk[1] = 3'b000; wrap_acc[1] = 1'b1; wrap_bst[1] = 1'b1;
        wrap_addr[2] = 32'h0000_0000; wrap_blk[2] = 3'b000; wrap_acc[2] = 1'b1; wrap_bst[2] = 1'b1;
        wrap_addr[3] = 32'h0000_0008; wrap_blk[3] = 3'b010; wrap_acc[3] = 1'b0; wrap_bst[3] = 1'b0;
        wrap_addr[4] = 32'h0000_0008; wrap_blk[4] = 3'b000; wrap_acc[4] = 1'b1; wrap_bst[4] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_access = 3'b010;
            in_block  = wrap_blk[c];
            out_wait  = 1'b0;
            in_packet[1*PW +: PW] = mk(wrap_addr[c], 1'b1, 2'b11, 32'h77);
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d out_access", c), rr_access, wrap_acc[c]);
            check($sformatf("wrap%0d out_burst", c),  rr_burst,  wrap_bst[c]);
            if (wrap_acc[c])
                check($sformatf("wrap%0d out_dst", c), dst_of(rr_packet), wrap_addr[c]);
        end

        // ---------------- reset while holding a locked beat ----------------
        @(negedge clk);
        out_wait = 1'b1;
        in_packet[1*PW +: PW] = mk(32'h10, 1'b1, 2'b11, 32'h78);
        @(posedge clk);
        #1;
        check("stall hold out_access", rr_access, 1'b1);
        check("stall hold out_dst", dst_of(rr_packet), 32'h8);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out_access", rr_access, 1'b0);
        check("midreset out_burst",  rr_burst,  1'b0);
        check("midreset out_packet", rr_packet, '0);
        @(negedge clk);
        reset     = 1'b0;
        out_wait  = 1'b0;
        in_block  = '0;
        in_access = 3'b111;
        for (int i = 0; i < NCH; i++)
            in_packet[i*PW +: PW] = mk(32'h2000 + 32'(i * 32'h100), 1'b1, 2'b11, 32'h0);
        #2;
        check("postreset in_wait", rr_wait, 3'b110);
        @(posedge clk);
        #1;
        check("postreset out_chan",  rr_chan,  3'b001);
        check("postreset out_burst", rr_burst, 1'b0);
        @(posedge clk);
        #1;
        check("postreset2 out_chan",  rr_chan,  3'b010);
        check("postreset2 out_burst", rr_burst, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
